// File: rtl/d_bus_resp.sv
// CPU data-bus responder: register RAM below IO_BASE, memory-mapped LED, cycle counter
// and (with DBUS_TIMER_EN defined) a reloadable countdown timer driving irq.
module d_bus_resp #(
  parameter logic [7:0] IO_BASE = 8'hF0,
  parameter int         DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic [DATA_W-1:0] led,
  output logic              irq
);

  localparam int         RAM_DEPTH  = int'(IO_BASE);
  localparam logic [7:0] OFF_LED    = 8'd0;
  localparam logic [7:0] OFF_CYCLE  = 8'd1;
`ifdef DBUS_TIMER_EN
  localparam logic [7:0] OFF_RELOAD = 8'd2;
  localparam logic [7:0] OFF_CTRL   = 8'd3;
  localparam logic [7:0] OFF_COUNT  = 8'd4;
`endif

  // Bus handshake: there is none; a load is answered combinationally in the same
  // cycle and a store (we=1) is committed on the next rising clk edge.

  logic              is_io;
  logic [7:0]        io_off;
  logic              io_wr;
  logic              wr_led;

  assign is_io  = (addr >= IO_BASE);
  assign io_off = addr - IO_BASE;
  assign io_wr  = we && is_io;
  assign wr_led = io_wr && (io_off == OFF_LED);

  // ---------------------------------------------------------------------------
  // Register RAM (not reset)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we && !is_io) begin
      ram[addr] <= datain;
    end
  end

  // ---------------------------------------------------------------------------
  // LED register and free-running cycle counter
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] led_r;
  logic [DATA_W-1:0] cycle_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_r <= '0;
    end else if (wr_led) begin
      led_r <= datain;
    end
  end

  // Writes to CYCLE are deliberately ignored; it only ever counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_r <= '0;
    end else begin
      cycle_r <= cycle_r + 1'b1;
    end
  end

  assign led = led_r;

`ifdef DBUS_TIMER_EN
  // ---------------------------------------------------------------------------
  // Countdown timer
  // ---------------------------------------------------------------------------
  logic              wr_reload;
  logic              wr_ctrl;
  logic              wr_count;
  logic              expire;
  logic [DATA_W-1:0] reload_r;
  logic [DATA_W-1:0] count_r;
  logic              en_r;
  logic              exp_r;

  assign wr_reload = io_wr && (io_off == OFF_RELOAD);
  assign wr_ctrl   = io_wr && (io_off == OFF_CTRL);
  assign wr_count  = io_wr && (io_off == OFF_COUNT);

  // Uses the registered enable, so an EN write only affects the edge after it lands.
  assign expire = en_r && (count_r == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_r <= '0;
      count_r  <= '0;
      en_r     <= 1'b0;
      exp_r    <= 1'b0;
    end else begin
      if (wr_reload) begin
        reload_r <= datain;
      end
      if (wr_ctrl) begin
        en_r <= datain[0];
      end
      // A software clear loses against an expiry on the same edge.
      if (expire) begin
        exp_r <= 1'b1;
      end else if (wr_ctrl && datain[1]) begin
        exp_r <= 1'b0;
      end
      if (wr_count) begin
        count_r <= datain;
      end else if (expire) begin
        count_r <= reload_r;
      end else if (en_r) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

  assign irq = exp_r;
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Combinational read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    dataout = '0;
    if (!is_io) begin
      dataout = ram[addr];
    end else begin
      case (io_off)
        OFF_LED:    dataout = led_r;
        OFF_CYCLE:  dataout = cycle_r;
`ifdef DBUS_TIMER_EN
        OFF_RELOAD: dataout = reload_r;
        OFF_CTRL:   dataout = {{(DATA_W-2){1'b0}}, exp_r, en_r};
        OFF_COUNT:  dataout = count_r;
`endif
        default:    dataout = '0;
      endcase
    end
  end

endmodule

// File: doc/d_bus_resp.md
# d_bus_resp

Responder on the CPU data bus: answers every load/store the pipelined CPU issues on `d_addr`/`d_we`/`d_dataout`/`d_datain`. It replaces the plain data memory in the top level. Addresses below `IO_BASE` hit a 16-bit register RAM; addresses from `IO_BASE` up hit memory-mapped I/O: LED output register, free-running cycle counter and a reloadable countdown timer. Reads are combinational, so the CPU's memory stage needs no extra wait cycles.

## Interface
- `IO_BASE`, default 8'hF0: first I/O address. RAM occupies 0 .. IO_BASE-1.
- `DATA_W`, default 16: bus data width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `addr` input 8: byte-less word address from CPU `d_addr`.
- `we` input 1: store strobe from CPU `d_we`; write committed on rising `clk` edge.
- `datain` input DATA_W: store data from CPU `d_dataout`.
- `dataout` output DATA_W: load data to CPU `d_datain`, combinational from `addr`.
- `led` output DATA_W: LED register contents.
- `irq` output 1: timer-expired flag (sticky), level.

## Operation
- RAM: IO_BASE words × DATA_W. `we`=1 with `addr`<IO_BASE writes `datain` at the edge. Read of RAM returns current contents (write-then-read in the next cycle sees new data; same-cycle read returns old data).
- I/O map (offset from IO_BASE):
  - +0 LED: R/W. `led` follows register.
  - +1 CYCLE: read-only, free-running up counter, +1 every cycle, wraps FFFF→0000. Writes ignored.
  - +2 RELOAD: R/W timer reload value.
  - +3 CTRL: bit0 EN (R/W), bit1 EXP (read; write 1 clears, write 0 no effect), bits15:2 read 0.
  - +4 COUNT: R/W current countdown value; write loads directly.
  - +5 .. +15: read 0, writes ignored.
- Timer (per cycle, EN=1): COUNT≠0 → COUNT−1. COUNT=0 → COUNT←RELOAD, EXP←1. EN=0: COUNT holds.
- `irq` = EXP.
- Priority in one cycle:
  - CPU write to COUNT beats timer decrement/reload.
  - Expiry sets EXP in the same cycle software writes 1 to clear it: set wins, EXP stays 1.
  - Write to RELOAD takes effect at the next reload, not current count.
  - Write to CTRL with EN=1 and COUNT=0 already: expiry evaluated on the following edge.
- RELOAD=0 with EN=1: expires every cycle.

## Timing
- Read latency 0 (combinational `dataout`); write latency 1 edge.
- CYCLE read returns pre-edge value; first read after reset release returns number of elapsed edges.
- Reset (`rst`=0, asynchronous): `led`=0, `irq`=0, CYCLE=0, RELOAD=0, COUNT=0, EN=0, EXP=0. RAM contents not reset (undefined until written). `dataout` reflects reset registers for I/O addresses immediately.
- Reset asserted mid-countdown: timer stops, all I/O registers clear; release resumes with EN=0.
- EN write 0→1 at edge k: first decrement at edge k+1.

## Configuration
- `DBUS_TIMER_EN` defined: RELOAD, CTRL, COUNT and `irq` behave as above.
- Undefined: timer logic not built; offsets +2..+4 read 0, writes ignored, `irq` tied 0. RAM, LED, CYCLE unchanged.

## Test plan
- Store 16'hBEEF to 8'h10, load 8'h10 next cycle → `dataout`=16'hBEEF; load 8'h11 unaffected.
- Store 16'h00A5 to IO_BASE+0 → `led`=16'h00A5 after edge; store to IO_BASE+1 → CYCLE keeps counting, read returns count, not written value.
- Reset release, read IO_BASE+1 after 10 edges → 16'd10; force CYCLE to FFFF (run 65535 cycles) → next read 0000.
- RELOAD=3, COUNT=3, EN=1 → COUNT 2,1,0 then reload 3 with `irq`=1 on the 4th edge after enable; write CTRL=16'h0003 → EXP cleared, irq 0.
- Write CTRL bit1=1 on the exact expiry edge → EXP remains 1.
- Assert `rst` low mid-countdown (COUNT=5) → immediately COUNT=0, EN=0, `irq`=0, `led`=0; with `DBUS_TIMER_EN` undefined, IO_BASE+2..+4 read 0 and `irq`=0 always.
